audio_tone_gen: RTL and testbench

Stereo test-tone source feeding the I2S clock-domain-crossing stage from the system clock side. It produces one stereo sample per request pulse (the CDC stage's data-ready strobe), using per-channel phase accumulators and a selectable waveform. After reset it pre-fills the downstream async FIFO with a burst of samples so the I2S reader never starts on an empty FIFO.

---
 rtl/audio_tone_gen.sv | 130 +++++++++++++
 tb/tb_audio_tone_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// Stereo test-tone source: one L/R sample per i_sample_req, PRIME unrequested samples after reset; AUDIO_TONE_VOLUME_EN enables volume shift.
// Latency 4 cycles request->o_data_valid; no backpressure, requests while busy or priming are dropped and latch o_overrun.
module audio_tone_gen #(
  parameter int DATA_BIT  = 16,
  parameter int PHASE_BIT = 24,
  parameter int PRIME     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic [PHASE_BIT-1:0] i_tune_l,
  input  logic [PHASE_BIT-1:0] i_tune_r,
  input  logic [1:0]           i_wave_sel,
  input  logic [3:0]           i_volume,
  input  logic                 i_sample_req,
  output logic [DATA_BIT-1:0]  o_audio_l,
  output logic [DATA_BIT-1:0]  o_audio_r,
  output logic                 o_data_valid,
  output logic                 o_overrun
);

  typedef enum logic [2:0] {IDLE, PHASE, SHAPE, SCALE, OUT} state_t;

  state_t                state;
  logic [PHASE_BIT-1:0]  acc_l, acc_r;
  logic [3:0]            prime_cnt;
  logic                  en_q;
  logic [1:0]            wave_q;
  logic [DATA_BIT-1:0]   p_l, p_r;
  logic [DATA_BIT-1:0]   s_l, s_r;

`ifdef AUDIO_TONE_VOLUME_EN
  logic [3:0]            vol_q;
`else
  logic                  unused_volume;
  assign unused_volume = ^i_volume;
`endif

  function automatic logic [DATA_BIT-1:0] shape(input logic [DATA_BIT-1:0] p,
                                                input logic [1:0]          wave,
                                                input logic                en);
    logic                m;
    logic [DATA_BIT-2:0] f;
    logic [DATA_BIT-1:0] r;
    m = p[DATA_BIT-1];
    f = m ? ~p[DATA_BIT-2:0] : p[DATA_BIT-2:0];
    r = '0;
    if (en) begin
      case (wave)
        2'd0:    r = m ? {1'b1, {(DATA_BIT-2){1'b0}}, 1'b1} : {1'b0, {(DATA_BIT-1){1'b1}}};
        2'd1:    r = {~m, p[DATA_BIT-2:0]};
        // Folded ramp doubled to full scale, then offset-binary to two's complement.
        2'd2:    r = {~f[DATA_BIT-2], f[DATA_BIT-3:0], 1'b0};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      acc_l        <= '0;
      acc_r        <= '0;
      prime_cnt    <= 4'(PRIME);
      en_q         <= 1'b0;
      wave_q       <= 2'd0;
      p_l          <= '0;
      p_r          <= '0;
      s_l          <= '0;
      s_r          <= '0;
`ifdef AUDIO_TONE_VOLUME_EN
      vol_q        <= 4'd0;
`endif
      o_audio_l    <= '0;
      o_audio_r    <= '0;
      o_data_valid <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      // Requests are never queued: busy or still priming means the request is lost.
      if (i_sample_req && (state != IDLE || prime_cnt != 4'd0))
        o_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (i_sample_req || prime_cnt != 4'd0)
            state <= PHASE;
        end
        PHASE: begin
          en_q   <= i_enable;
          wave_q <= i_wave_sel;
`ifdef AUDIO_TONE_VOLUME_EN
          vol_q  <= i_volume;
`endif
          p_l    <= acc_l[PHASE_BIT-1 -: DATA_BIT];
          p_r    <= acc_r[PHASE_BIT-1 -: DATA_BIT];
          if (i_enable) begin
            acc_l <= acc_l + i_tune_l;
            acc_r <= acc_r + i_tune_r;
          end
          state  <= SHAPE;
        end
        SHAPE: begin
          s_l   <= shape(p_l, wave_q, en_q);
          s_r   <= shape(p_r, wave_q, en_q);
          state <= SCALE;
        end
        SCALE: begin
`ifdef AUDIO_TONE_VOLUME_EN
          o_audio_l <= $signed(s_l) >>> vol_q;
          o_audio_r <= $signed(s_r) >>> vol_q;
`else
          o_audio_l <= s_l;
          o_audio_r <= s_r;
`endif
          o_data_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (prime_cnt != 4'd0)
            prime_cnt <= prime_cnt - 4'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed-vector bench for audio_tone_gen: priming, waveforms, volume, overrun and mid-sample reset.
module tb_audio_tone_gen;

`ifdef AUDIO_TONE_VOLUME_EN
  localparam bit VOL_EN = 1'b1;
`else
  localparam bit VOL_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_enable;
  logic [23:0] i_tune_l, i_tune_r;
  logic [1:0]  i_wave_sel;
  logic [3:0]  i_volume;
  logic        i_sample_req;
  logic [15:0] o_audio_l, o_audio_r;
  logic        o_data_valid, o_overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  wave;
    logic        en;
    logic [3:0]  vol;
    logic [23:0] tl, tr;
    logic [15:0] el, er;
  } vec_t;

  vec_t vecs[$];

  audio_tone_gen dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (i_enable),
    .i_tune_l     (i_tune_l),
    .i_tune_r     (i_tune_r),
    .i_wave_sel   (i_wave_sel),
    .i_volume     (i_volume),
    .i_sample_req (i_sample_req),
    .o_audio_l    (o_audio_l),
    .o_audio_r    (o_audio_r),
    .o_data_valid (o_data_valid),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] wave, input logic en, input logic [3:0] vol,
                     input logic [23:0] tl, input logic [23:0] tr,
                     input logic [15:0] el, input logic [15:0] er);
    vec_t v;
    v.wave = wave; v.en = en; v.vol = vol; v.tl = tl; v.tr = tr; v.el = el; v.er = er;
    vecs.push_back(v);
  endtask

  // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic do_req(input string name, input logic [15:0] el, input logic [15:0] er);
    int          lat;
    logic [15:0] l, r;
    lat = 0; l = '0; r = '0;
    i_sample_req = 1'b1;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge i_clk);
      i_sample_req = 1'b0;
      if (o_data_valid) begin
        lat = k; l = o_audio_l; r = o_audio_r;
      end
    end
    check({name, " latency"}, lat, 4);
    if (lat != 0) begin
      check({name, " left"}, l, el);
      check({name, " right"}, r, er);
      @(negedge i_clk);
      check({name, " valid one cycle"}, o_data_valid, 1'b0);
      check({name, " left held"}, o_audio_l, el);
    end
  endtask

  // Releases reset at the current negedge and watches the priming burst.
  task automatic prime_run(input string name, input logic [15:0] base, input logic [15:0] step,
                           input bit poke_last, input logic exp_ovr);
    int n;
    int idx[4];
    logic [15:0] e;
    n = 0;
    idx = '{0, 0, 0, 0};
    i_reset_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      i_sample_req = 1'b0;
      if (o_data_valid) begin
        if (n < 4) begin
          idx[n] = c;
          e = base + 16'(n) * step;
          check($sformatf("%s sample%0d left", name, n), o_audio_l, e);
          check($sformatf("%s sample%0d right", name, n), o_audio_r, e);
        end
        n++;
        if (poke_last && n == 4) i_sample_req = 1'b1;
      end
    end
    check({name, " pulse count"}, n, 4);
    check({name, " first pulse cycle"}, idx[0], 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("%s spacing%0d", name, i), idx[i] - idx[i-1], 5);
    check({name, " overrun"}, o_overrun, exp_ovr);
  endtask

  initial begin
    int pulses;
    int holds;

    // Vectors start from phase 0 on both channels; each consumes one request.
    add(2'd0, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'h7FFF, 16'h7FFF);
    add(2'd0, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'h7FFF, 16'h7FFF);
    add(2'd0, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'h8001, 16'h7FFF);
    add(2'd0, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'h8001, 16'h7FFF);
    add(2'd1, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'h8000, 16'hC000);
    add(2'd1, 1'b0, 4'd0, 24'h400000, 24'h100000, 16'h0000, 16'h0000);
    add(2'd1, 1'b0, 4'd0, 24'h400000, 24'h100000, 16'h0000, 16'h0000);
    add(2'd1, 1'b0, 4'd0, 24'h400000, 24'h100000, 16'h0000, 16'h0000);
    add(2'd1, 1'b1, 4'd0, 24'h400000, 24'h100000, 16'hC000, 16'hD000);
    add(2'd2, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'h7FFE, 16'h4000);
    add(2'd2, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'h3FFE, 16'h6000);
    add(2'd2, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'hFFFE, 16'h7FFE);
    add(2'd2, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'hBFFE, 16'h5FFE);
    add(2'd2, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'h8000, 16'h3FFE);
    add(2'd3, 1'b1, 4'd0, 24'h200000, 24'h100000, 16'h0000, 16'h0000);
    add(2'd2, 1'b1, 4'd0, 24'hC00000, 24'h100000, 16'h0000, 16'hFFFE);
    add(2'd1, 1'b1, 4'd1, 24'h000000, 24'h000000,
        VOL_EN ? 16'hC000 : 16'h8000, VOL_EN ? 16'h2800 : 16'h5000);
    add(2'd1, 1'b1, 4'd15, 24'h000000, 24'h000000,
        VOL_EN ? 16'hFFFF : 16'h8000, VOL_EN ? 16'h0000 : 16'h5000);
    add(2'd0, 1'b1, 4'd4, 24'h000000, 24'h000000,
        VOL_EN ? 16'h07FF : 16'h7FFF, VOL_EN ? 16'hF800 : 16'h8001);

    i_reset_n    = 1'b0;
    i_enable     = 1'b1;
    i_tune_l     = 24'h010000;
    i_tune_r     = 24'h010000;
    i_wave_sel   = 2'd1;
    i_volume     = 4'd0;
    i_sample_req = 1'b0;

    repeat (3) @(negedge i_clk);
    check("reset audio_l", o_audio_l, 16'h0000);
    check("reset audio_r", o_audio_r, 16'h0000);
    check("reset valid", o_data_valid, 1'b0);
    check("reset overrun", o_overrun, 1'b0);

    prime_run("prime saw", 16'h8000, 16'h0100, 1'b0, 1'b0);

    // Re-prime with the tone disabled so both accumulators sit at phase 0.
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_enable = 1'b0;
    prime_run("prime off", 16'h0000, 16'h0000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      i_wave_sel = vecs[i].wave;
      i_enable   = vecs[i].en;
      i_volume   = vecs[i].vol;
      i_tune_l   = vecs[i].tl;
      i_tune_r   = vecs[i].tr;
      do_req($sformatf("vec%0d", i), vecs[i].el, vecs[i].er);
    end
    check("overrun clear after vectors", o_overrun, 1'b0);

    // Second request lands two cycles after the first, while the DUT is in SHAPE.
    pulses = 0;
    i_sample_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge i_clk);
      i_sample_req = (k == 2);
      if (o_data_valid) pulses++;
    end
    check("overrun pulse count", pulses, 1);
    check("overrun set", o_overrun, 1'b1);
    do_req("after overrun", vecs[vecs.size()-1].el, vecs[vecs.size()-1].er);
    check("overrun sticky", o_overrun, 1'b1);

    // Reset lands while the sample is in SHAPE.
    i_wave_sel = 2'd1;
    i_enable   = 1'b1;
    i_volume   = 4'd0;
    i_tune_l   = 24'h010000;
    i_tune_r   = 24'h010000;
    i_sample_req = 1'b1;
    @(negedge i_clk);
    i_sample_req = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    check("mid reset overrun cleared", o_overrun, 1'b0);
    check("mid reset audio_l", o_audio_l, 16'h0000);
    holds = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_data_valid) holds++;
    end
    check("mid reset no valid", holds, 0);

    // Priming restarts from phase 0; a request on the last priming OUT is dropped.
    prime_run("reprime", 16'h8000, 16'h0100, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
